// File: rtl/cpu_control_unit_if.sv
// rtl/cpu_control_unit_if.sv - memory and ALU bus between the control unit and its datapath blocks
interface cpu_control_unit_if;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic [7:0] mem_dout;
    logic [2:0] alu_op;
    logic       alu_en;
    logic [7:0] alu_result;

    modport master (
        output mem_addr, mem_din, mem_we, alu_op, alu_en,
        input  mem_dout, alu_result
    );

    modport slave (
        input  mem_addr, mem_din, mem_we, alu_op, alu_en,
        output mem_dout, alu_result
    );
endinterface

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - accumulator CPU sequencer; define INDIRECT_EN to enable indirect addressing
module cpu_control_unit (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        resume,
    cpu_control_unit_if.master          bus,
    output logic [3:0]                  pc,
    output logic [7:0]                  ir,
    output logic [7:0]                  ac,
    output logic [3:0]                  state,
    output logic                        halted
);

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_IND0   = 4'd4,
        S_IND1   = 4'd5,
        S_EXEC0  = 4'd6,
        S_EXEC1  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] ar;
    logic       mem_we_q;
    logic       alu_en_q;
    logic       halted_q;
    logic       mem_we_d;
    logic       alu_en_d;
    logic       halted_d;

    logic [2:0] op;
    logic       is_mref;
    logic       is_alu_mem;
    logic       is_alu_reg;
    logic       go_indirect;

    assign op         = ir[6:4];
    assign is_mref    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
                        (op == OP_LDA) || (op == OP_STA);
    assign is_alu_mem = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
    assign is_alu_reg = (op == OP_SHL) || (op == OP_CMA);

`ifdef INDIRECT_EN
    assign go_indirect = ir[7] && is_mref;
`else
    assign go_indirect = 1'b0;
`endif

    // State register plus the registered strobes, so they are glitch-free state decodes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_FETCH0;
            mem_we_q <= 1'b0;
            alu_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_we_q <= mem_we_d;
            alu_en_q <= alu_en_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_HLT)
                    state_d = S_HALT;
                else if (go_indirect)
                    state_d = S_IND0;
                else
                    state_d = S_EXEC0;
            end
`ifdef INDIRECT_EN
            S_IND0:   state_d = S_IND1;
            S_IND1:   state_d = S_EXEC0;
`endif
            S_EXEC0:  state_d = (op == OP_STA || is_alu_reg) ? S_FETCH0 : S_EXEC1;
            S_EXEC1:  state_d = S_FETCH0;
            S_HALT:   state_d = resume ? S_FETCH0 : S_HALT;
            default:  state_d = S_FETCH0;
        endcase
    end

    // Strobe values for the state being entered; IR is already stable by DECODE
    always_comb begin
        mem_we_d = 1'b0;
        alu_en_d = 1'b0;
        halted_d = 1'b0;
        if (state_d == S_EXEC0 && op == OP_STA)
            mem_we_d = 1'b1;
        if ((state_d == S_EXEC0 && is_alu_reg) || (state_d == S_EXEC1 && is_alu_mem))
            alu_en_d = 1'b1;
        if (state_d == S_HALT)
            halted_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= 4'd0;
            ir <= 8'd0;
            ac <= 8'd0;
            ar <= 4'd0;
        end else begin
            case (state_q)
                S_FETCH0: ar <= pc;
                S_FETCH2: begin
                    ir <= bus.mem_dout;
                    pc <= pc + 4'd1;
                end
                S_DECODE: ar <= ir[3:0];
                S_IND1:   ar <= bus.mem_dout[3:0];
                S_EXEC0: begin
                    if (is_alu_reg)
                        ac <= bus.alu_result;
                end
                S_EXEC1: begin
                    if (is_alu_mem)
                        ac <= bus.alu_result;
                    else if (op == OP_LDA)
                        ac <= bus.mem_dout;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = ar;
    assign bus.mem_din  = ac;
    assign bus.mem_we   = mem_we_q;
    assign bus.alu_op   = op;
    assign bus.alu_en   = alu_en_q;
    assign state        = state_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed bench for cpu_control_unit with memory and ALU models
module tb_cpu_control_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       resume = 1'b0;
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] ac;
    logic [3:0] state;
    logic       halted;

    logic [7:0] mem [16];
    logic       ld_en = 1'b0;
    logic [3:0] ld_addr = 4'd0;
    logic [7:0] ld_data = 8'd0;

    int errors = 0;
    int checks = 0;
    int cnt;

`ifdef INDIRECT_EN
    localparam int IND_EXTRA = 2;
    localparam logic [7:0] IND_AC = 8'h02;
    localparam logic [3:0] IND_AR = 4'd9;
`else
    localparam int IND_EXTRA = 0;
    localparam logic [7:0] IND_AC = 8'h0A;
    localparam logic [3:0] IND_AR = 4'd8;
`endif

    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .CLK    (CLK),
        .RST    (RST),
        .resume (resume),
        .bus    (bus),
        .pc     (pc),
        .ir     (ir),
        .ac     (ac),
        .state  (state),
        .halted (halted)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_result = ac + bus.mem_dout;
            3'b001:  bus.alu_result = ac - bus.mem_dout;
            3'b010:  bus.alu_result = ac ^ bus.mem_dout;
            3'b011:  bus.alu_result = ac + ac;
            3'b110:  bus.alu_result = ~ac;
            default: bus.alu_result = ac;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick(1);
        ld_en   = 1'b0;
    endtask

    task automatic reset_and_clear();
        RST = 1'b1;
        for (int i = 0; i < 16; i++)
            wr(i[3:0], 8'h00);
    endtask

    initial begin
        // Reset values
        reset_and_clear();
        chk("rst_pc", pc, 4'd0);
        chk("rst_ir", ir, 8'd0);
        chk("rst_ac", ac, 8'd0);
        chk("rst_state", state, 4'd0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_alu_en", bus.alu_en, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_addr", bus.mem_addr, 4'd0);

        // Reset during EXEC0 of STA aborts the write
        wr(4'd0, 8'h57);
        wr(4'd7, 8'h33);
        RST = 1'b0;
        tick(4);
        chk("sta_exec0_state", state, 4'd6);
        chk("sta_exec0_we", bus.mem_we, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        chk("abort_we", bus.mem_we, 1'b0);
        chk("abort_state", state, 4'd0);
        chk("abort_pc", pc, 4'd0);
        chk("abort_ir", ir, 8'd0);
        tick(1);
        chk("abort_mem7", mem[7], 8'h33);
        RST = 1'b0;
        tick(1);
        chk("abort_restart_state", state, 4'd1);
        chk("abort_restart_addr", bus.mem_addr, 4'd0);

        // Direct program: LDA 5, ADD 6, STA 7, HLT
        reset_and_clear();
        wr(4'd0, 8'h45);
        wr(4'd1, 8'h06);
        wr(4'd2, 8'h57);
        wr(4'd3, 8'h70);
        wr(4'd5, 8'h07);
        wr(4'd6, 8'h03);
        RST = 1'b0;
        tick(6);
        chk("lda_ac", ac, 8'h07);
        chk("lda_state", state, 4'd0);
        chk("lda_pc", pc, 4'd1);
        tick(6);
        chk("add_ac", ac, 8'h0A);
        chk("add_pc", pc, 4'd2);
        tick(4);
        chk("sta_we", bus.mem_we, 1'b1);
        chk("sta_addr", bus.mem_addr, 4'd7);
        chk("sta_din", bus.mem_din, 8'h0A);
        tick(1);
        chk("sta_we_drop", bus.mem_we, 1'b0);
        chk("sta_mem7", mem[7], 8'h0A);
        tick(4);
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_state", state, 4'd8);
        chk("hlt_pc", pc, 4'd4);

        // HALT holds, then resume restarts fetch at current pc
        tick(10);
        chk("hold_state", state, 4'd8);
        chk("hold_pc", pc, 4'd4);
        chk("hold_ac", ac, 8'h0A);
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        chk("resume_state", state, 4'd0);
        chk("resume_halted", halted, 1'b0);
        tick(1);
        chk("resume_fetch_addr", bus.mem_addr, 4'd4);
        tick(5);
        chk("resume_add_ac", ac, 8'h4F);

        // Indirect ADD (direct when indirect addressing is compiled out)
        reset_and_clear();
        wr(4'd0, 8'h4A);
        wr(4'd10, 8'h01);
        wr(4'd1, 8'h88);
        wr(4'd8, 8'h09);
        wr(4'd9, 8'h01);
        wr(4'd2, 8'h70);
        RST = 1'b0;
        tick(6);
        chk("ind_pre_ac", ac, 8'h01);
        tick(4 + IND_EXTRA);
        chk("ind_exec0_state", state, 4'd6);
        chk("ind_exec0_addr", bus.mem_addr, IND_AR);
        tick(2);
        chk("ind_state", state, 4'd0);
        chk("ind_ac", ac, IND_AC);

        // Register ops: SHL then CMA
        reset_and_clear();
        wr(4'd0, 8'h4A);
        wr(4'd10, 8'h81);
        wr(4'd1, 8'h30);
        wr(4'd2, 8'h60);
        wr(4'd3, 8'h70);
        RST = 1'b0;
        tick(6);
        chk("reg_pre_ac", ac, 8'h81);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.alu_en) cnt++;
        end
        chk("shl_alu_en_cnt", cnt, 1);
        chk("shl_ac", ac, 8'h02);
        chk("shl_state", state, 4'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.alu_en) cnt++;
        end
        chk("cma_alu_en_cnt", cnt, 1);
        chk("cma_ac", ac, 8'hFD);
        chk("cma_state", state, 4'd0);

        // PC wrap: 15 SHLs of zero, then CMA at address 15
        reset_and_clear();
        for (int i = 0; i < 15; i++)
            wr(i[3:0], 8'h30);
        wr(4'd15, 8'h60);
        RST = 1'b0;
        tick(75);
        chk("wrap_pre_pc", pc, 4'd15);
        chk("wrap_pre_ac", ac, 8'h00);
        tick(5);
        chk("wrap_ac", ac, 8'hFF);
        chk("wrap_pc", pc, 4'd0);
        chk("wrap_state", state, 4'd0);
        tick(1);
        chk("wrap_fetch_addr", bus.mem_addr, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
